// File: rtl/ray_tracer_pkg.sv
// Shared types and defaults for the ray-tracing frame scheduler.
// Holds the scheduler state encoding and the active-core clamp helper.
package ray_tracer_pkg;

    localparam int MAX_CORES_DEFAULT = 4;
    localparam int X_BITS_DEFAULT    = 11;
    localparam int Y_BITS_DEFAULT    = 11;
    localparam int EXTRA_BITS        = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

    // Highest usable core index: requested extra cores, limited to the physical core count.
    function automatic int clamp_last_core(input logic [EXTRA_BITS-1:0] extra, input int max_cores);
        return (int'(extra) > (max_cores - 1)) ? (max_cores - 1) : int'(extra);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x,y) walker: x runs 0..width-1, then wraps with y+1; the whole frame
// wraps back to (0,0) after the last pixel.
module raster_counter
    import ray_tracer_pkg::*;
#(
    parameter int X_BITS = X_BITS_DEFAULT,
    parameter int Y_BITS = Y_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [X_BITS-1:0] width_i,
    input  logic [Y_BITS-1:0] height_i,
    output logic [X_BITS-1:0] x_o,
    output logic [Y_BITS-1:0] y_o,
    output logic              last_in_line_o,
    output logic              last_in_frame_o
);

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;

    assign last_in_line_o  = (x_q == (width_i - X_BITS'(1)));
    assign last_in_frame_o = last_in_line_o && (y_q == (height_i - Y_BITS'(1)));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (last_in_line_o) begin
                x_d = '0;
                y_d = last_in_frame_o ? '0 : (y_q + Y_BITS'(1));
            end else begin
                x_d = x_q + X_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/core_scheduler.sv
// Frame scheduler: dispatches raster-ordered (x,y) jobs to the compute cores in strict
// round-robin and tags pixels leaving the pixel buffer with start-of-frame / end-of-line.
module core_scheduler
    import ray_tracer_pkg::*;
#(
    parameter int MAX_CORES = MAX_CORES_DEFAULT,
    parameter int X_BITS    = X_BITS_DEFAULT,
    parameter int Y_BITS    = Y_BITS_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  frame_start,
    input  logic [X_BITS-1:0]     frame_width,
    input  logic [Y_BITS-1:0]     frame_height,
    input  logic [EXTRA_BITS-1:0] no_of_extra_cores,
    input  logic [MAX_CORES-1:0]  core_ready,
    output logic [MAX_CORES-1:0]  core_start,
    output logic [X_BITS-1:0]     job_x,
    output logic [Y_BITS-1:0]     job_y,
    input  logic                  pix_accept,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W  = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
    localparam int N_BITS = X_BITS + Y_BITS;

    sched_state_t      state_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic [X_BITS-1:0] width_q;
    logic [Y_BITS-1:0] height_q;
    logic [N_BITS-1:0] pix_cnt_q;

    logic              accept;
    logic              zero_size;
    logic              xfer;
    logic              pix_count_en;
    logic [N_BITS-1:0] frame_pixels;
    logic [IDX_W-1:0]  last_idx_d;

    logic [X_BITS-1:0] disp_x;
    logic [Y_BITS-1:0] disp_y;
    logic              disp_last_line;
    logic              disp_last_frame;
    logic [X_BITS-1:0] out_x;
    logic [Y_BITS-1:0] out_y;
    logic              out_last_line;
    logic              out_last_frame;
    logic              unused_status;

    assign accept       = frame_start && (state_q == IDLE);
    assign zero_size    = (frame_width == '0) || (frame_height == '0);
    assign xfer         = (state_q == DISPATCH) && core_ready[idx_q];
    assign pix_count_en = pix_accept && ((state_q == DISPATCH) || (state_q == DRAIN));
    assign frame_pixels = N_BITS'(width_q) * N_BITS'(height_q);
    assign last_idx_d   = IDX_W'(clamp_last_core(no_of_extra_cores, MAX_CORES));

    // Frame completion is decided by the pixel count, so the raster wrap flags are informational.
    assign unused_status = ^{disp_last_line, out_last_frame};

    raster_counter #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_dispatch_cnt (
        .clk             (aclk),
        .rst_n           (aresetn),
        .clear_i         (accept),
        .advance_i       (xfer),
        .width_i         (width_q),
        .height_i        (height_q),
        .x_o             (disp_x),
        .y_o             (disp_y),
        .last_in_line_o  (disp_last_line),
        .last_in_frame_o (disp_last_frame)
    );

    raster_counter #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_output_cnt (
        .clk             (aclk),
        .rst_n           (aresetn),
        .clear_i         (accept),
        .advance_i       (pix_count_en),
        .width_i         (width_q),
        .height_i        (height_q),
        .x_o             (out_x),
        .y_o             (out_y),
        .last_in_line_o  (out_last_line),
        .last_in_frame_o (out_last_frame)
    );

    // The offer stays on the same core until it takes the job: no skipping of stalled cores.
    always_comb begin
        core_start = '0;
        if (state_q == DISPATCH) begin
            core_start[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            pix_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    if (accept) begin
                        width_q      <= frame_width;
                        height_q     <= frame_height;
                        last_idx_q   <= last_idx_d;
                        idx_q        <= '0;
                        pix_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        frame_done_q <= zero_size;
                        state_q      <= zero_size ? DONE : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (pix_count_en) begin
                        pix_cnt_q <= pix_cnt_q + N_BITS'(1);
                    end
                    if (xfer) begin
                        idx_q <= (idx_q == last_idx_q) ? '0 : (idx_q + IDX_W'(1));
                        if (disp_last_frame) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pix_count_en) begin
                        pix_cnt_q <= pix_cnt_q + N_BITS'(1);
                    end
                    if (pix_cnt_q == frame_pixels) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign job_x      = disp_x;
    assign job_y      = disp_y;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign out_sof    = busy_q && (out_x == '0) && (out_y == '0);
    assign out_eol    = busy_q && out_last_line;

endmodule
